ospfb_phase_rotator: RTL

- Per-frame circular-shift stage for the oversampled PFB. Sits between the polyphase FIR output and the parallel FFT.
- Implements the oversampling phase correction: output frame n is input frame n circularly rotated by s_n = (n*DEC_FAC) mod FFT_LEN.
- Ping-pong frame buffer with AXI-Stream handshakes on both sides.
- Generalises the fixed 3/4 oversampling case to any DEC_FAC/FFT_LEN pair and any lane count, and adds a runtime bypass mode.

---
 rtl/ospfb_phase_rotator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ospfb_phase_rotator.sv
// Per-frame circular rotation stage for the oversampled PFB: ping-pong frame buffer
// where output frame n is input frame n rotated by (n*DEC_FAC) mod FFT_LEN samples.
module ospfb_phase_rotator #(
   parameter int  WIDTH        = 16,
   parameter int  SAMP_PER_CLK = 2,
   parameter int  FFT_LEN      = 128,
   parameter int  DEC_FAC      = 96,
   localparam int DW           = WIDTH * SAMP_PER_CLK,
   localparam int FW           = FFT_LEN / SAMP_PER_CLK,
   localparam int AW           = $clog2(FW)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [DW-1:0] s_axis_tdata,
   input  logic          s_axis_tvalid,
   output logic          s_axis_tready,
   input  logic          s_axis_tlast,
   output logic [DW-1:0] m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          m_axis_tlast,
   output logic [AW-1:0] m_axis_tuser,
   input  logic          bypass,
   output logic          frame_err
);

   localparam logic [AW:0]   FW_W   = (AW+1)'(FW);
   localparam logic [AW:0]   D_STEP = (AW+1)'(DEC_FAC / SAMP_PER_CLK);
   localparam logic [AW-1:0] LAST   = AW'(FW - 1);
   localparam logic [AW-1:0] ONE    = AW'(1);

   logic [DW-1:0] mem [2**(AW+1)];

   logic          run;
   logic          wr_bank;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] acc;
   logic          byp_q;
   logic [1:0]    full;
   logic [1:0]    full_next;
   logic [AW-1:0] off_q [2];

   logic          rd_bank;
   logic [AW-1:0] rd_idx;
   logic          s1_valid;
   logic          s1_last;
   logic [AW-1:0] s1_user;
   logic [DW-1:0] s1_data;

   logic          wr_fire, wr_end, byp_frame;
   logic [AW:0]   acc_sum;
   logic [AW-1:0] acc_next;
   logic          out_ready, rd_issue, rd_end;
   logic [AW:0]   rd_sum;
   logic [AW-1:0] rd_addr;

   assign s_axis_tready = run && !full[wr_bank];
   assign wr_fire       = s_axis_tvalid && s_axis_tready;
   assign wr_end        = (wr_idx == LAST);
   assign byp_frame     = (wr_idx == '0) ? bypass : byp_q;

   // Offset advances by D/SPC words per frame, wrapped by a single conditional subtract.
   assign acc_sum  = {1'b0, acc} + D_STEP;
   assign acc_next = (acc_sum >= FW_W) ? AW'(acc_sum - FW_W) : acc_sum[AW-1:0];

   assign out_ready = !m_axis_tvalid || m_axis_tready;
   assign rd_issue  = full[rd_bank] && (!s1_valid || out_ready);
   assign rd_end    = (rd_idx == LAST);
   assign rd_sum    = {1'b0, rd_idx} + {1'b0, off_q[rd_bank]};
   assign rd_addr   = (rd_sum >= FW_W) ? AW'(rd_sum - FW_W) : rd_sum[AW-1:0];

   // A bank is released once its last word has been read out of the buffer,
   // so the writer can refill it while that word is still in the output pipe.
   always_comb begin
      // NOTE: default first so no path through this block leaves full_next unassigned (no latch).
      full_next = full;
      if (rd_issue && rd_end) full_next[rd_bank] = 1'b0;
      if (wr_fire && wr_end)  full_next[wr_bank] = 1'b1;
   end

   // NOTE: the frame buffer carries no reset; validity is tracked by the full flags alone.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[{wr_bank, wr_idx}] <= s_axis_tdata;
      if (rd_issue) s1_data <= mem[{rd_bank, rd_addr}];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run       <= 1'b0;
         wr_bank   <= 1'b0;
         wr_idx    <= '0;
         acc       <= '0;
         byp_q     <= 1'b0;
         full      <= '0;
         off_q[0]  <= '0;
         off_q[1]  <= '0;
         frame_err <= 1'b0;
      end else begin
         run       <= 1'b1;
         full      <= full_next;
         frame_err <= wr_fire && (s_axis_tlast != wr_end);
         if (wr_fire) begin
            if (wr_idx == '0) byp_q <= bypass;
            if (wr_end) begin
               wr_idx         <= '0;
               wr_bank        <= ~wr_bank;
               off_q[wr_bank] <= byp_frame ? '0 : acc;
               acc            <= acc_next;
            end else begin
               wr_idx <= wr_idx + ONE;
            end
         end
      end
   end

   // s1 is the skid stage: it holds buffer read data whenever the output register is stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_bank       <= 1'b0;
         rd_idx        <= '0;
         s1_valid      <= 1'b0;
         s1_last       <= 1'b0;
         s1_user       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
      end else begin
         if (rd_issue) begin
            rd_idx   <= rd_end ? '0 : rd_idx + ONE;
            s1_valid <= 1'b1;
            s1_last  <= rd_end;
            s1_user  <= off_q[rd_bank];
            if (rd_end) rd_bank <= ~rd_bank;
         end else if (out_ready) begin
            s1_valid <= 1'b0;
         end
         if (out_ready) begin
            m_axis_tvalid <= s1_valid;
            if (s1_valid) begin
               m_axis_tdata <= s1_data;
               m_axis_tlast <= s1_last;
               m_axis_tuser <= s1_user;
            end
         end
      end
   end

endmodule
